// File: rtl/bist_pkg.sv
// bist_pkg: shared state encoding and helpers for the BIST scheduler.
// Imported by bist_scheduler and bist_watchdog.
package bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_START  = 3'd2,
    S_ARM    = 3'd3,
    S_WAIT   = 3'd4,
    S_RECORD = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam int DEF_TIMEOUT = 64;

  function automatic logic rise(
    input logic cur,
    input logic prev
  );
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/bist_watchdog.sv
// bist_watchdog: per-core wait counter for the BIST scheduler.
// Cleared on each start pulse, counts while enabled, flags expiry.
module bist_watchdog
  import bist_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter int TO_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] count;

  // Expiry is the cycle whose increment lands on TIMEOUT_CYCLES-1.
  assign expired = enable &&
    (count == TO_W'(TIMEOUT_CYCLES - 2));

  // Count cycles spent waiting on the core under test.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + TO_W'(1);
    end
  end

endmodule

// File: rtl/bist_scheduler.sv
// bist_scheduler: runs per-core BIST controllers in index order.
// Define BIST_SCHED_RETRY_EN to rerun a failing core once.
module bist_scheduler
  import bist_pkg::*;
#(
  parameter int NUM_CORES      = 4,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter int IDX_W = $clog2(NUM_CORES + 1),
  parameter int TO_W  = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sched_start,
  input  logic [NUM_CORES-1:0] core_mask,
  input  logic [NUM_CORES-1:0] core_bist_end,
  input  logic [NUM_CORES-1:0] core_pass,
  output logic [NUM_CORES-1:0] core_bist_start,
  output logic                 busy,
  output logic                 sched_done,
  output logic [IDX_W-1:0]     cur_core,
  output logic [NUM_CORES-1:0] result_pass,
  output logic [NUM_CORES-1:0] result_timeout,
  output logic                 all_pass
`ifdef BIST_SCHED_RETRY_EN
  ,
  output logic [NUM_CORES-1:0] retried
`endif
);

  state_t               state;
  logic                 prev_start;
  logic [NUM_CORES-1:0] mask_q;
  logic [NUM_CORES-1:0] sel;
  logic                 hit_mask;
  logic                 hit_end;
  logic                 hit_pass;
  logic                 at_last;
  logic                 wd_clear;
  logic                 wd_en;
  logic                 wd_expired;

  // One-hot decode of the current index.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      sel[i] = (cur_core == IDX_W'(i));
    end
  end

  assign hit_mask = |(mask_q & sel);
  assign hit_end  = |(core_bist_end & sel);
  assign hit_pass = |(core_pass & sel);
  assign at_last  = (cur_core == IDX_W'(NUM_CORES));
  assign wd_clear = (state == S_START);
  assign wd_en    = (state == S_ARM) ||
                    (state == S_WAIT);

  bist_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W(TO_W)
  ) u_wd (
    .clock(clock),
    .reset(reset),
    .clear(wd_clear),
    .enable(wd_en),
    .expired(wd_expired)
  );

  // Sequencer: index scan, start pulse, end wait, result capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      prev_start      <= 1'b0;
      mask_q          <= '0;
      cur_core        <= '0;
      core_bist_start <= '0;
      busy            <= 1'b0;
      sched_done      <= 1'b0;
      result_pass     <= '0;
      result_timeout  <= '0;
      all_pass        <= 1'b0;
`ifdef BIST_SCHED_RETRY_EN
      retried         <= '0;
`endif
    end else begin
      prev_start      <= sched_start;
      core_bist_start <= '0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (rise(sched_start, prev_start)) begin
            mask_q         <= core_mask;
            cur_core       <= '0;
            result_pass    <= '0;
            result_timeout <= '0;
            all_pass       <= 1'b0;
            sched_done     <= 1'b0;
            busy           <= 1'b1;
`ifdef BIST_SCHED_RETRY_EN
            retried        <= '0;
`endif
            state          <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (at_last) begin
            busy       <= 1'b0;
            sched_done <= 1'b1;
            all_pass   <= &(result_pass | ~mask_q);
            state      <= S_DONE;
          end else if (hit_mask) begin
            core_bist_start <= sel;
            state           <= S_START;
          end else begin
            cur_core <= cur_core + IDX_W'(1);
          end
        end
        S_START: begin
          state <= S_ARM;
        end
        S_ARM: begin
          // A level left high by an earlier run is skipped here.
          if (!hit_end) begin
            state <= S_WAIT;
          end else if (wd_expired) begin
            result_timeout <= result_timeout | sel;
            result_pass    <= result_pass & ~sel;
            state          <= S_RECORD;
          end
        end
        S_WAIT: begin
          if (hit_end) begin
`ifdef BIST_SCHED_RETRY_EN
            if (!hit_pass && !(|(retried & sel))) begin
              retried         <= retried | sel;
              core_bist_start <= sel;
              state           <= S_START;
            end else begin
              result_pass <= (result_pass & ~sel) |
                (sel & {NUM_CORES{hit_pass}});
              state       <= S_RECORD;
            end
`else
            result_pass <= (result_pass & ~sel) |
              (sel & {NUM_CORES{hit_pass}});
            state       <= S_RECORD;
`endif
          end else if (wd_expired) begin
            result_timeout <= result_timeout | sel;
            result_pass    <= result_pass & ~sel;
            state          <= S_RECORD;
          end
        end
        S_RECORD: begin
          cur_core <= cur_core + IDX_W'(1);
          state    <= S_SELECT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
